// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM states, ACK/NACK line levels,
// general-call address and the modulo-9 bit counter helper.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX,
    ST_RX_ACK,
    ST_TX,
    ST_TX_ACK,
    ST_IGNORE
  } state_t;

  // SDA level during the 9th clock: low acknowledges, high refuses
  localparam logic SDA_ACK  = 1'b0;
  localparam logic SDA_NACK = 1'b1;

  // General call is deliberately never claimed by this target
  localparam logic [6:0] GEN_CALL_ADDR = 7'h00;

  // Bit counter value while the ACK bit (9th SCL clock) is on the bus
  localparam logic [3:0] ACK_BIT = 4'd8;

  function automatic logic [3:0] bit_cnt_next(input logic [3:0] cnt);
    return (cnt == ACK_BIT) ? 4'd0 : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Input synchronizer plus edge detector for one I2C line.
// The chain and the history flop reset to 1 (idle bus level), so releasing
// reset on an idle bus produces no edge.
module i2c_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the pin through the synchronizer and keep one cycle of history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= '1;
      prev  <= 1'b1;
    end else begin
      chain <= {chain[STAGES-2:0], pin};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/i2c_target.sv
// I2C target (no clock stretching, 7-bit address, general call ignored).
// Optional read support is built when macro I2C_TARGET_READ_EN is defined;
// without it a matching read address is NACKed and tx_load stays low.
module i2c_target
  import i2c_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  input  logic [6:0] addr_own,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       busy,
  output logic       stop_det
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (scl),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (sda),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  state_t     state;
  logic [3:0] bit_cnt;
  logic [6:0] shreg;
  logic       sda_low;
  logic [7:0] byte_in;
  logic       start_seen;
  logic       stop_seen;
  logic       addr_hit;
  logic       addr_accept;

  assign sda = sda_low ? 1'b0 : 1'bz;

  // Both conditions use the synchronized SCL level, so SDA activity while
  // SCL is low (normal data changes) is never mistaken for START/STOP.
  assign start_seen = sda_fall & scl_lvl;
  assign stop_seen  = sda_rise & scl_lvl;

  // Byte as it stands including the bit being sampled on this SCL rise
  assign byte_in  = {shreg, sda_lvl};
  assign addr_hit = (byte_in[7:1] == addr_own) && (byte_in[7:1] != GEN_CALL_ADDR);

`ifdef I2C_TARGET_READ_EN
  logic [7:0] tx_shreg;
  logic       rw;

  assign addr_accept = addr_hit;
`else
  logic unused_tx;

  assign addr_accept = addr_hit & ~byte_in[0];
  assign unused_tx   = ^tx_data;
  assign tx_load     = 1'b0;
`endif

  // Protocol FSM: START/STOP override everything, otherwise act on SCL edges
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      sda_low  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      stop_det <= 1'b0;
`ifdef I2C_TARGET_READ_EN
      tx_shreg <= '0;
      rw       <= 1'b0;
      tx_load  <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      stop_det <= 1'b0;
`ifdef I2C_TARGET_READ_EN
      tx_load  <= 1'b0;
`endif
      if (start_seen) begin
        state   <= ST_ADDR;
        bit_cnt <= '0;
        sda_low <= 1'b0;
        busy    <= 1'b1;
      end else if (stop_seen) begin
        state    <= ST_IDLE;
        sda_low  <= 1'b0;
        stop_det <= 1'b1;
        busy     <= 1'b0;
      end else begin
        if (scl_rise && state != ST_IDLE && state != ST_IGNORE) begin
          bit_cnt <= bit_cnt_next(bit_cnt);
        end
        case (state)
          ST_IDLE: ;
          ST_IGNORE: ;
          ST_ADDR: begin
            if (scl_rise) begin
              shreg <= byte_in[6:0];
              if (bit_cnt == 4'd7) begin
                state <= addr_accept ? ST_ADDR_ACK : ST_IGNORE;
`ifdef I2C_TARGET_READ_EN
                rw    <= byte_in[0];
`endif
              end
            end
          end
          // Fall after bit 8 starts the ACK; fall after the 9th rise ends it
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (bit_cnt == ACK_BIT) begin
                sda_low <= 1'b1;
              end else begin
                sda_low <= 1'b0;
                state   <= ST_RX;
`ifdef I2C_TARGET_READ_EN
                if (rw) begin
                  tx_shreg <= tx_data;
                  tx_load  <= 1'b1;
                  sda_low  <= ~tx_data[7];
                  state    <= ST_TX;
                end
`endif
              end
            end
          end
          ST_RX: begin
            if (scl_rise) begin
              shreg <= byte_in[6:0];
              if (bit_cnt == 4'd7) begin
                rx_data  <= byte_in;
                rx_valid <= 1'b1;
                state    <= ST_RX_ACK;
              end
            end
          end
          ST_RX_ACK: begin
            if (scl_fall) begin
              if (bit_cnt == ACK_BIT) begin
                sda_low <= 1'b1;
              end else begin
                sda_low <= 1'b0;
                state   <= ST_RX;
              end
            end
          end
`ifdef I2C_TARGET_READ_EN
          // MSB was presented when entering; each fall presents the next bit
          ST_TX: begin
            if (scl_rise && bit_cnt == 4'd7) begin
              state <= ST_TX_ACK;
            end
            if (scl_fall) begin
              sda_low  <= ~tx_shreg[6];
              tx_shreg <= {tx_shreg[6:0], 1'b0};
            end
          end
          // NACK leaves at the 9th rise; ACK reloads at the fall that follows
          ST_TX_ACK: begin
            if (scl_rise && sda_lvl == SDA_NACK) begin
              state <= ST_IGNORE;
            end
            if (scl_fall) begin
              if (bit_cnt == ACK_BIT) begin
                sda_low <= 1'b0;
              end else begin
                tx_shreg <= tx_data;
                tx_load  <= 1'b1;
                sda_low  <= ~tx_data[7];
                state    <= ST_TX;
              end
            end
          end
`endif
          default: begin
            state   <= ST_IDLE;
            sda_low <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Scoreboard bench for i2c_target: a bit-banged controller issues frames and
// queues the events the target must produce; a monitor pops and compares.
module tb_i2c_target;

  localparam int Q = 8;

  typedef enum logic [1:0] {EV_RX, EV_TXL, EV_STOP} ev_kind_t;
  typedef struct packed {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl = 1'b1;
  logic       ctrl_low = 1'b0;
  logic [6:0] addr_own = 7'h01;
  logic [7:0] tx_data = 8'h80;
  logic [7:0] rx_data;
  logic       rx_valid, tx_load, busy, stop_det;
  wire        sda_bus;

  assign sda_bus = ctrl_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  int   total = 0;
  int   bad = 0;
  int   txl_count = 0;
  logic target_drove = 1'b0;
  ev_t  exp_q[$];

  always #5 clk = ~clk;

  i2c_target #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda      (sda_bus),
    .addr_own (addr_own),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .busy     (busy),
    .stop_det (stop_det)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic mon_event(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d expected none", k);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(k), 32'(e.kind));
      if (k == EV_RX) check("rx_data", 32'(d), 32'(e.data));
    end
  endtask

  // Monitor: consume every output pulse against the expected-event queue
  always @(negedge clk) begin
    if (reset) begin
      if (rx_valid) mon_event(EV_RX, rx_data);
      if (tx_load) begin
        txl_count++;
        mon_event(EV_TXL, 8'h00);
      end
      if (stop_det) begin
        mon_event(EV_STOP, 8'h00);
        check("busy_at_stop", 32'(busy), 32'd0);
      end
      if (!ctrl_low && sda_bus === 1'b0) target_drove = 1'b1;
    end
  end

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    ctrl_low = 1'b0; wq();
    scl = 1'b1;      wq();
    ctrl_low = 1'b1; wq();
    scl = 1'b0;      wq();
  endtask

  task automatic i2c_stop();
    ctrl_low = 1'b1; wq();
    scl = 1'b1;      wq();
    ctrl_low = 1'b0; wq();
  endtask

  task automatic write_bit(input logic b);
    ctrl_low = ~b; wq();
    scl = 1'b1;    wq(); wq();
    scl = 1'b0;    wq();
  endtask

  task automatic read_bit(output logic b);
    ctrl_low = 1'b0; wq();
    scl = 1'b1;      wq();
    b = sda_bus;     wq();
    scl = 1'b0;      wq();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic ack_val, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack_val);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] d;

    // Reset values
    repeat (4) @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_tx_load", 32'(tx_load), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_stop_det", 32'(stop_det), 32'd0);
    check("reset_sda", 32'(sda_bus), 32'd1);
    reset = 1'b1;
    wq();

    // Write: address 0x02 then data 0x10
    i2c_start();
    check("busy_after_start", 32'(busy), 32'd1);
    write_byte(8'h02, ack);
    check("wr_addr_ack", 32'(ack), 32'd0);
    expect_ev(EV_RX, 8'h10);
    write_byte(8'h10, ack);
    check("wr_data_ack", 32'(ack), 32'd0);
    expect_ev(EV_STOP, 8'h00);
    i2c_stop();
    wq();
    check("wr_busy_low", 32'(busy), 32'd0);
    check("wr_rx_data", 32'(rx_data), 32'h10);

    // Address mismatch: 0x04 is address 0x02
    target_drove = 1'b0;
    i2c_start();
    write_byte(8'h04, ack);
    check("mis_addr_nack", 32'(ack), 32'd1);
    write_byte(8'h55, ack);
    check("mis_data_nack", 32'(ack), 32'd1);
    expect_ev(EV_STOP, 8'h00);
    i2c_stop();
    check("mis_sda_never_low", 32'(target_drove), 32'd0);

    // Read: address 0x03, tx_data 0x80, controller ACKs then NACKs
    tx_data = 8'h80;
    txl_count = 0;
    i2c_start();
`ifdef I2C_TARGET_READ_EN
    expect_ev(EV_TXL, 8'h00);
    write_byte(8'h03, ack);
    check("rd_addr_ack", 32'(ack), 32'd0);
    expect_ev(EV_TXL, 8'h00);
    read_byte(1'b0, d);
    check("rd_byte0", 32'(d), 32'h80);
    read_byte(1'b1, d);
    check("rd_byte1", 32'(d), 32'h80);
    target_drove = 1'b0;
    write_byte(8'h00, ack);
    check("rd_ignore_nack", 32'(ack), 32'd1);
    check("rd_ignore_released", 32'(target_drove), 32'd0);
    check("rd_busy_in_ignore", 32'(busy), 32'd1);
    expect_ev(EV_STOP, 8'h00);
    i2c_stop();
    check("rd_tx_load_count", 32'(txl_count), 32'd2);
`else
    write_byte(8'h03, ack);
    check("rd_addr_nack", 32'(ack), 32'd1);
    expect_ev(EV_STOP, 8'h00);
    i2c_stop();
    check("rd_tx_load_count", 32'(txl_count), 32'd0);
`endif

    // Repeated START after four data bits
    i2c_start();
    write_byte(8'h02, ack);
    check("rs_addr0_ack", 32'(ack), 32'd0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_start();
    write_byte(8'h02, ack);
    check("rs_addr1_ack", 32'(ack), 32'd0);
    expect_ev(EV_RX, 8'h5A);
    write_byte(8'h5A, ack);
    check("rs_data_ack", 32'(ack), 32'd0);
    expect_ev(EV_STOP, 8'h00);
    i2c_stop();

    // Reset asserted while the target is ACKing a data byte
    i2c_start();
    write_byte(8'h02, ack);
    check("rst_addr_ack", 32'(ack), 32'd0);
    expect_ev(EV_RX, 8'h33);
    d = 8'h33;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    ctrl_low = 1'b0;
    @(negedge clk);
    check("rst_ack_driven", 32'(sda_bus), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_sda_released", 32'(sda_bus), 32'd1);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_load", 32'(tx_load), 32'd0);
    check("rst_stop_det", 32'(stop_det), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wq();
    scl = 1'b1; wq(); wq();
    scl = 1'b0; wq();
    write_byte(8'h77, ack);
    check("rst_frame_ignored", 32'(ack), 32'd1);
    expect_ev(EV_STOP, 8'h00);
    i2c_stop();
    i2c_start();
    write_byte(8'h02, ack);
    check("post_rst_addr_ack", 32'(ack), 32'd0);
    expect_ev(EV_RX, 8'h99);
    write_byte(8'h99, ack);
    check("post_rst_data_ack", 32'(ack), 32'd0);
    expect_ev(EV_STOP, 8'h00);
    i2c_stop();
    wq();
    check("post_rst_rx_data", 32'(rx_data), 32'h99);

    wq();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the flip-flop depth of the SCL/SDA input synchronizers (legal 2..3).
REQ-002 SHALL have port clk, input, 1 bit: system clock, rising-edge active.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset; the block is held reset while reset=0.
REQ-004 SHALL have port scl, input, 1 bit: I2C clock from the controller; the block never drives SCL and does no clock stretching.
REQ-005 SHALL have port sda, inout, 1 bit: open-drain data line, driven only 1'b0 or 1'bz.
REQ-006 SHALL have port addr_own, input, 7 bits: this target's address, sampled at each address-byte compare.
REQ-007 SHALL have port rx_data, output, 8 bits: last byte received, MSB first.
REQ-008 SHALL have port rx_valid, output, 1 bit: one-clk pulse when rx_data updates.
REQ-009 SHALL have port tx_data, input, 8 bits: byte returned on a read.
REQ-010 SHALL have port tx_load, output, 1 bit: one-clk pulse when tx_data is captured.
REQ-011 SHALL have port busy, output, 1 bit: high from detected START to detected STOP.
REQ-012 SHALL have port stop_det, output, 1 bit: one-clk pulse on STOP.

Function
REQ-013 SHALL synchronize SCL and SDA through SYNC_STAGES flip-flops and detect edges on the synchronized signals; an SCL pin edge is therefore acted on SYNC_STAGES+1 clk later.
REQ-014 SHALL decode START/repeated START as SDA falling while SCL high, and STOP as SDA rising while SCL high; both are honoured in every state.
REQ-015 SHALL implement states IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK and IGNORE.
REQ-016 SHALL handle START from any state as follows: go to ADDR, clear the bit counter and release SDA.
REQ-017 SHALL handle STOP from any state as follows: go to IDLE, release SDA and pulse stop_det.
REQ-018 SHALL sample SDA on the SCL rising edge and change its own SDA drive only on the SCL falling edge.
REQ-019 SHALL, in ADDR after 8 bits: if bits[7:1]==addr_own, go to ADDR_ACK and drive SDA low for exactly the 9th SCL clock; otherwise go to IGNORE and leave SDA released.
REQ-020 SHALL treat address 7'h00 (general call) as non-matching.
REQ-021 SHALL, after ADDR_ACK with R/W=0, go to RX; after the 8th data bit, load rx_data, pulse rx_valid one clk after that SCL rising edge is detected, and ACK in RX_ACK; then return to RX.
REQ-022 SHALL, after ADDR_ACK with R/W=1, capture tx_data and pulse tx_load on the falling edge that ends the ACK bit, then shift it MSB first in TX.
REQ-023 SHALL, in TX_ACK, sample the controller's ACK: ACK (0) loads the next byte via tx_load and returns to TX; NACK (1) goes to IGNORE.
REQ-024 SHALL, in IGNORE, keep SDA released and wait only for START or STOP.
REQ-025 SHALL increment the bit counter modulo 9 per SCL rising edge; it never overflows past the ACK bit.

Reset
REQ-026 SHALL, while reset=0, force state IDLE, SDA released, rx_data=8'h00, rx_valid=0, tx_load=0, busy=0, stop_det=0, and synchronizers to 1.
REQ-027 SHALL treat reset deassertion mid-transfer as follows: stay in IDLE, ignore the current frame and wait for the next START.

Configuration
REQ-028 SHALL implement read support under macro I2C_TARGET_READ_EN: when it is defined, REQ-022/023 apply.
REQ-029 SHALL, when I2C_TARGET_READ_EN is undefined, omit the TX/TX_ACK logic, NACK a matching address with R/W=1 (go to IGNORE), tie tx_load to 0 and leave tx_data unused.

Structure
REQ-030 SHALL place the state enumeration, the ACK/NACK constants and the general-call address constant in shared package i2c_pkg.
REQ-031 SHALL implement the synchronizer and edge detector as sub-module i2c_sync_edge, instantiated once each for SCL and SDA.

Verification
REQ-032 SHALL cover a write: addr_own=7'h01, controller writes 0x02 then data 0x10 -> ACK on both 9th bits, one rx_valid with rx_data=8'h10, stop_det pulse, busy low.
REQ-033 SHALL cover a mismatch: addr_own=7'h01, controller sends 0x04 (address 7'h02) -> SDA never driven low, controller sees ack_fail, no rx_valid.
REQ-034 SHALL cover a read with I2C_TARGET_READ_EN defined: address byte 0x03, tx_data=8'h80, controller ACKs then NACKs -> bytes 0x80,0x80 on SDA, two tx_load pulses, then IGNORE until STOP.
REQ-035 SHALL cover the same read with I2C_TARGET_READ_EN undefined -> address NACKed, tx_load stays 0.
REQ-036 SHALL cover a repeated START after bit 4 of a data byte -> no rx_valid, back to ADDR, next address 0x02 ACKed.
REQ-037 SHALL cover reset=0 asserted during RX_ACK -> SDA released within the same clk, all outputs at reset values, next full write received correctly.
